// File: rtl/rambam_rand_feeder_pkg.sv
// Shared types and constants for the rambam randomness feeder and its LFSR.
// Holds the default vector geometry, the Galois LFSR mask and the feeder FSM states.
package rambam_pkg;

    localparam int RAMBAM_D        = 4;
    localparam int RAMBAM_NUM_RAND = 23;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef logic [0:RAMBAM_NUM_RAND-1][0:RAMBAM_D-1] rand_vect_t;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        LAUNCH,
        BUSY
    } feeder_state_t;

    // Right-shifting Galois step; a nonzero state never maps to zero.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/rambam_rand_feeder_lfsr32.sv
// 32-bit Galois LFSR with a step enable and a d-bit low-order tap.
// Resets asynchronously (active-low) to SEED, with a zero seed forced to 1.
module rambam_lfsr32
    import rambam_pkg::*;
#(
    parameter int          d    = 4,
    parameter logic [31:0] SEED = 32'h0000_0001
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    output logic [d-1:0] tap
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= SEED_EFF;
        end else if (step) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign tap = lfsr[d-1:0];

endmodule

// File: rtl/rambam_rand_feeder.sv
// Front end for rambam_aes_multiple_sbox: captures a request, fills the mask vector from an LFSR, then starts the core and waits for it.
// Optional RAMBAM_NONZERO_RAND_EN: zero LFSR taps are skipped so every mask word is nonzero.
module rambam_rand_feeder
    import rambam_pkg::*;
#(
    parameter int          d        = 4,
    parameter int          NUM_RAND = 23,
    parameter logic [31:0] SEED     = 32'h0000_0001
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [0:127]                   plaintext_i,
    input  logic [0:127]                   key_i,
    output logic [0:127]                   core_plaintext,
    output logic [0:127]                   core_key,
    output logic [0:NUM_RAND-1][0:d-1]     core_random_vect,
    output logic                           core_drdy_i,
    input  logic                           core_drdy_o,
    output logic                           done_o
);

    localparam int               IDX_W    = (NUM_RAND > 1) ? $clog2(NUM_RAND) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAND - 1);

    feeder_state_t    state;
    feeder_state_t    next_state;
    logic [IDX_W-1:0] idx;
    logic [d-1:0]     tap;
    logic             tap_ok;
    logic             lfsr_step;
    logic             word_write;

    rambam_lfsr32 #(
        .d    (d),
        .SEED (SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (lfsr_step),
        .tap  (tap)
    );

`ifdef RAMBAM_NONZERO_RAND_EN
    assign tap_ok = (tap != '0);
`else
    assign tap_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The LFSR runs on every GEN cycle, even when a word is rejected.
    always_comb begin
        next_state  = state;
        req_ready   = 1'b0;
        core_drdy_i = 1'b0;
        lfsr_step   = 1'b0;
        word_write  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = GEN;
                end
            end
            GEN: begin
                lfsr_step  = 1'b1;
                word_write = tap_ok;
                if (tap_ok && (idx == LAST_IDX)) begin
                    next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                core_drdy_i = 1'b1;
                next_state  = BUSY;
            end
            BUSY: begin
                if (core_drdy_o) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_plaintext   <= '0;
            core_key         <= '0;
            core_random_vect <= '0;
            idx              <= '0;
            done_o           <= 1'b0;
        end else begin
            done_o <= (state == BUSY) && core_drdy_o;
            if ((state == IDLE) && req_valid) begin
                core_plaintext <= plaintext_i;
                core_key       <= key_i;
                idx            <= '0;
            end
            if (word_write) begin
                core_random_vect[idx] <= tap;
                idx                   <= idx + 1'b1;
            end
        end
    end

endmodule
